// File: rtl/rv32i_types.sv
// Shared CPU types: arbiter FSM state and the captured memory request.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } mem_arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

  localparam logic GRANT_IMEM = 1'b0;
  localparam logic GRANT_DMEM = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational tie-break between fetch and data requests.
// MEM_ARBITER_RR_EN: round-robin on last_grant; otherwise dmem always wins a tie.
module mem_arb_pick
  import rv32i_types::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant_i,
  output logic grant_d
);

`ifdef MEM_ARBITER_RR_EN
  always_comb begin
    grant_i = i_req;
    grant_d = d_req;
    if (i_req && d_req) begin
      // The port that did not win last time takes the tie.
      grant_d = (last_grant == GRANT_IMEM);
      grant_i = !grant_d;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  assign grant_d = d_req;
  assign grant_i = i_req & ~d_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle unified memory between the CPU fetch and data ports.
// MEM_ARBITER_RR_EN selects round-robin tie-break; default is fixed dmem priority.
module mem_arbiter
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  mem_arb_state_t state_q, state_d;
  mem_req_t       req_q, req_d;
  logic           i_req, d_req;
  logic           grant_i, grant_d;
  logic           last_grant;

  assign i_req = |imem_rmask;
  assign d_req = |(dmem_rmask | dmem_wmask);

`ifdef MEM_ARBITER_RR_EN
  logic last_grant_q, last_grant_d;

  assign last_grant = last_grant_q;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE) begin
      if (grant_d)      last_grant_d = GRANT_DMEM;
      else if (grant_i) last_grant_d = GRANT_IMEM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= GRANT_IMEM;
    else      last_grant_q <= last_grant_d;
  end
`else
  assign last_grant = GRANT_IMEM;
`endif

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    imem_resp  = 1'b0;
    imem_rdata = '0;
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    mem_addr   = '0;
    mem_rmask  = '0;
    mem_wmask  = '0;
    mem_wdata  = '0;

    // Memory only sees the held request while a grant is outstanding.
    if (state_q != IDLE) begin
      mem_addr  = req_q.addr;
      mem_rmask = req_q.rmask;
      mem_wmask = req_q.wmask;
      mem_wdata = req_q.wdata;
    end

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          req_d   = '{addr: dmem_addr, rmask: dmem_rmask,
                      wmask: dmem_wmask, wdata: dmem_wdata};
          state_d = BUSY_D;
        end else if (grant_i) begin
          req_d   = '{addr: imem_addr, rmask: imem_rmask,
                      wmask: 4'h0, wdata: 32'h0};
          state_d = BUSY_I;
        end
      end
      BUSY_I: begin
        if (mem_resp) begin
          imem_resp  = 1'b1;
          imem_rdata = mem_rdata;
          state_d    = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_resp) begin
          dmem_resp  = 1'b1;
          dmem_rdata = mem_rdata;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

endmodule
